// File: rtl/input_event_scanner.sv
// input_event_scanner: button debounce, quadrature decode and FWFT event queue
// for the I2C slave user-input board.
module input_event_scanner #(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = 350000,
  parameter int ENC_FILTER      = 0,
  parameter int QUAD_X4         = 0,
  parameter int POS_WIDTH       = 8,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rotary_a,
  input  logic                 rotary_b,
  input  logic [NUM_BTNS-1:0]  btn,
  output logic [NUM_BTNS-1:0]  btn_state,
  output logic [POS_WIDTH-1:0] position,
  input  logic                 pos_clr,
  output logic                 evt_valid,
  output logic [7:0]           evt_data,
  input  logic                 evt_rd,
  output logic                 evt_overflow,
  input  logic                 ovf_clr
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = (ENC_FILTER > 0) ? $clog2(ENC_FILTER + 1) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [NUM_BTNS-1:0] btn_s1;
  logic [NUM_BTNS-1:0] btn_s2;
  logic [1:0]          enc_s1;
  logic [1:0]          enc_s2;
  logic [1:0]          enc_cur;
  logic [1:0]          enc_prev;

  logic [DW-1:0]       db_cnt [NUM_BTNS];
  logic [NUM_BTNS-1:0] db_diff;
  logic [NUM_BTNS-1:0] db_fire;
  logic [NUM_BTNS-1:0] pend;
  logic [NUM_BTNS-1:0] svc;

  logic [1:0] idx_cur;
  logic [1:0] idx_prev;
  logic [1:0] delta;
  logic       enc_up;
  logic       enc_dn;
  logic       enc_ill;

  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic       full;
  logic       wr_en;
  logic       ovf_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // two-flop synchronisers on every asynchronous input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      enc_s1 <= '0;
      enc_s2 <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      enc_s1 <= {rotary_a, rotary_b};
      enc_s2 <= enc_s1;
    end
  end

  if (ENC_FILTER > 0) begin : g_filt
    logic [1:0]    cand;
    logic [1:0]    filt;
    logic [FW-1:0] fcnt;

    // accept a new {a,b} only once it has held steady long enough
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cand <= '0;
        filt <= '0;
        fcnt <= '0;
      end else begin
        cand <= enc_s2;
        if (enc_s2 != cand || enc_s2 == filt) begin
          fcnt <= '0;
        end else if (fcnt == FW'(ENC_FILTER - 1)) begin
          filt <= enc_s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
    end

    assign enc_cur = filt;
  end else begin : g_nofilt
    assign enc_cur = enc_s2;
  end

  // a button toggles on its last consecutive disagreeing cycle
  always_comb begin
    db_diff = '0;
    db_fire = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      db_diff[i] = btn_s2[i] ^ btn_state[i];
      db_fire[i] = db_diff[i] && (db_cnt[i] == DB_LAST);
    end
  end

  // per-button debounce counters, accepted levels and pending flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_state <= '0;
      pend      <= '0;
      for (int i = 0; i < NUM_BTNS; i++) db_cnt[i] <= '0;
    end else begin
      pend <= (pend & ~svc) | db_fire;
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (!db_diff[i] || db_fire[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
        if (db_fire[i]) btn_state[i] <= ~btn_state[i];
      end
    end
  end

  // Gray code to cycle index: 00->0, 01->1, 11->2, 10->3
  assign idx_cur  = {enc_cur[1], ^enc_cur};
  assign idx_prev = {enc_prev[1], ^enc_prev};
  assign delta    = idx_cur - idx_prev;

  // classify the transition; x1 mode counts only on arrival at 00
  always_comb begin
    enc_up  = 1'b0;
    enc_dn  = 1'b0;
    enc_ill = 1'b0;
    unique case (1'b1)
      delta == 2'd1: enc_up  = (QUAD_X4 != 0) || (enc_prev == 2'b10);
      delta == 2'd3: enc_dn  = (QUAD_X4 != 0) || (enc_prev == 2'b01);
      delta == 2'd2: enc_ill = 1'b1;
      default: ;
    endcase
  end

  // previous encoder state and wrapping position; clear beats a step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_prev <= '0;
      position <= '0;
    end else begin
      enc_prev <= enc_cur;
      if (pos_clr) begin
        position <= '0;
      end else if (enc_up) begin
        position <= position + POS_WIDTH'(1);
      end else if (enc_dn) begin
        position <= position - POS_WIDTH'(1);
      end
    end
  end

  // one push per cycle: encoder first, else lowest pending button
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    svc       = '0;
    if (enc_up || enc_dn || enc_ill) begin
      push      = 1'b1;
      push_data = enc_ill ? 8'hC0 : {7'b1000000, enc_up};
    end else begin
      for (int i = NUM_BTNS - 1; i >= 0; i--) begin
        if (pend[i]) begin
          push      = 1'b1;
          push_data = {1'b0, btn_state[i], 6'(i)};
          svc       = '0;
          svc[i]    = 1'b1;
        end
      end
    end
  end

  assign pop     = evt_rd && (count != '0);
  assign full    = (count == FULL_CNT);
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // event FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      evt_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      evt_overflow <= ovf_set || (evt_overflow && !ovf_clr);
    end
  end

  assign evt_valid = (count != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : 8'h00;

endmodule
